// File: rtl/bp_cache_assoc.sv
// Set-associative branch-prediction cache with true-LRU replacement.
// Two combinational lookup ports, one synchronous write/allocate port and a
// sequenced flush engine that walks the sets one per cycle while busy is high.
module bp_cache_assoc #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AWIDTH-1:0] ra0,
  output logic [DWIDTH-1:0] dout0,
  output logic              hit0,
  input  logic [AWIDTH-1:0] ra1,
  output logic [DWIDTH-1:0] dout1,
  output logic              hit1,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  input  logic              flush,
  output logic              busy
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = AWIDTH - IDX;
  localparam int AGEW = $clog2(WAYS);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                                 state_q;
  logic [IDX-1:0]                         ptr_q;
  logic                                   busy_q;
  logic [SETS-1:0][WAYS-1:0]              valid_q;
  logic [SETS-1:0][WAYS-1:0][AGEW-1:0]    age_q;
  logic [SETS-1:0][WAYS-1:0][TAG-1:0]     tag_q;
  logic [SETS-1:0][WAYS-1:0][DWIDTH-1:0]  data_q;

  logic [IDX-1:0]  widx;
  logic [TAG-1:0]  wtag;
  logic            write_en;
  logic            match_hit;
  logic            inv_hit;
  logic [AGEW-1:0] match_way;
  logic [AGEW-1:0] inv_way;
  logic [AGEW-1:0] lru_way;
  logic [AGEW-1:0] sel_way;
  logic [AGEW-1:0] old_age;

  // Returns {hit, data}; at most one way can match because writes reuse a match.
  function automatic logic [DWIDTH:0] lookup(
    input logic [AWIDTH-1:0]                        a,
    input logic [SETS-1:0][WAYS-1:0]                v,
    input logic [SETS-1:0][WAYS-1:0][TAG-1:0]       t,
    input logic [SETS-1:0][WAYS-1:0][DWIDTH-1:0]    d
  );
    logic [DWIDTH:0] r;
    logic [IDX-1:0]  i;
    r = '0;
    i = a[IDX-1:0];
    for (int w = 0; w < WAYS; w++) begin
      if (v[i][w] && (t[i][w] == a[AWIDTH-1:IDX])) r = {1'b1, d[i][w]};
    end
    return r;
  endfunction

  // Reads are masked while the flush engine owns the array.
  assign {hit0, dout0} = busy_q ? '0 : lookup(ra0, valid_q, tag_q, data_q);
  assign {hit1, dout1} = busy_q ? '0 : lookup(ra1, valid_q, tag_q, data_q);
  assign busy          = busy_q;

  assign widx     = wa[IDX-1:0];
  assign wtag     = wa[AWIDTH-1:IDX];
  assign write_en = we && (state_q == S_IDLE);
  assign old_age  = age_q[widx][sel_way];

  // Victim choice: existing match, else lowest invalid way, else the oldest way.
  always_comb begin
    match_hit = 1'b0;
    match_way = '0;
    inv_hit   = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    sel_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[widx][w] && (tag_q[widx][w] == wtag)) begin
        match_hit = 1'b1;
        match_way = AGEW'(w);
      end
      if (!valid_q[widx][w] && !inv_hit) begin
        inv_hit = 1'b1;
        inv_way = AGEW'(w);
      end
      if (age_q[widx][w] == AGEW'(WAYS - 1)) lru_way = AGEW'(w);
    end
    if (match_hit)    sel_way = match_way;
    else if (inv_hit) sel_way = inv_way;
    else              sel_way = lru_way;
  end

  // Control state: flush sequencer, valid bits and LRU ages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGEW'(w);
        end
      end
    end else if (state_q == S_IDLE) begin
      if (write_en) begin
        valid_q[widx][sel_way] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (AGEW'(w) == sel_way)           age_q[widx][w] <= '0;
          else if (age_q[widx][w] < old_age) age_q[widx][w] <= age_q[widx][w] + 1'b1;
        end
      end
      // A write in the same cycle lands first and is then cleared by the sweep.
      if (flush) begin
        state_q <= S_FLUSH;
        busy_q  <= 1'b1;
        ptr_q   <= '0;
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[ptr_q][w] <= 1'b0;
        age_q[ptr_q][w]   <= AGEW'(w);
      end
      ptr_q <= ptr_q + 1'b1;
      if (ptr_q == IDX'(SETS - 1)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  // Tag and payload storage; not reset, only qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tag_q[widx][sel_way]  <= wtag;
      data_q[widx][sel_way] <= din;
    end
  end

endmodule

// File: tb/tb_bp_cache_assoc.sv
// Self-checking bench for bp_cache_assoc (SETS=4, WAYS=2, AWIDTH=8, DWIDTH=8).
// Reference model: per-way full address and a last-write timestamp per way;
// the victim is the way with the oldest timestamp.
module tb_bp_cache_assoc;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] ra0 = '0, ra1 = '0, wa = '0;
  logic [DW-1:0] din = '0;
  logic          we = 1'b0, flush = 1'b0;
  logic [DW-1:0] dout0, dout1;
  logic          hit0, hit1, busy;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  bp_cache_assoc #(.AWIDTH(AW), .DWIDTH(DW), .SETS(NS), .WAYS(NW)) dut (
    .clk(clk), .reset_n(reset_n),
    .ra0(ra0), .dout0(dout0), .hit0(hit0),
    .ra1(ra1), .dout1(dout1), .hit1(hit1),
    .wa(wa), .din(din), .we(we), .flush(flush), .busy(busy)
  );

  // ---------------- reference model ----------------
  logic          m_valid [NS][NW];
  logic [AW-1:0] m_addr  [NS][NW];
  logic [DW-1:0] m_data  [NS][NW];
  int            m_last  [NS][NW];
  int            m_clock = 0;
  int            m_busy_left = 0;

  task automatic m_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_last[s][w]  = -w;
      end
  endtask

  task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int s, way;
    s = int'(a) % NS;
    way = -1;
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_addr[s][w] == a) way = w;
    if (way < 0)
      for (int w = 0; w < NW; w++)
        if (!m_valid[s][w] && way < 0) way = w;
    if (way < 0) begin
      way = 0;
      for (int w = 1; w < NW; w++)
        if (m_last[s][w] < m_last[s][way]) way = w;
    end
    m_clock++;
    m_valid[s][way] = 1'b1;
    m_addr[s][way]  = a;
    m_data[s][way]  = d;
    m_last[s][way]  = m_clock;
  endtask

  task automatic m_read(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    int s;
    s = int'(a) % NS;
    h = 1'b0;
    d = '0;
    if (m_busy_left == 0)
      for (int w = 0; w < NW; w++)
        if (m_valid[s][w] && m_addr[s][w] == a) begin
          h = 1'b1;
          d = m_data[s][w];
        end
  endtask

  // Advance model at a rising edge using the inputs present before it.
  task automatic m_edge();
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else begin
      if (we) m_write(wa, din);
      if (flush) begin
        m_clear();
        m_busy_left = NS;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) m_edge();
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wa = a; din = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    m_clear();
    m_busy_left = 0;
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    m_clear();
    m_busy_left = 0;
    ra0 = 8'h10; ra1 = 8'h24;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, hit0, dout0, hit1, dout1} !== 18'b0) begin
      failed++;
      $display("FAIL reset_outputs: busy=%b hit0=%b dout0=%h hit1=%b dout1=%h, required all zero",
               busy, hit0, dout0, hit1, dout1);
    end
    reset_n = 1'b1;
    tick();
    tests_run++;
    if ({hit0, dout0, hit1, dout1} !== 18'b0) begin
      failed++;
      $display("FAIL reset_empty: hit0=%b dout0=%h hit1=%b dout1=%h, required all zero",
               hit0, dout0, hit1, dout1);
    end
  endtask

  task automatic test_basic_write();
    wa = 8'h10; din = 8'hAA; we = 1'b1; ra0 = 8'h10;
    #1;
    tests_run++;
    if (hit0 !== 1'b0 || dout0 !== 8'h00) begin
      failed++;
      $display("FAIL write_same_cycle: hit0=%b dout0=%h, required 0/00", hit0, dout0);
    end
    tick();
    we = 1'b0;
    #1;
    tests_run++;
    if (hit0 !== 1'b1 || dout0 !== 8'hAA) begin
      failed++;
      $display("FAIL write_next_cycle: hit0=%b dout0=%h, required 1/aa", hit0, dout0);
    end
  endtask

  task automatic test_lru();
    do_reset();
    wr(8'h10, 8'h01);
    wr(8'h20, 8'h02);
    ra0 = 8'h10; ra1 = 8'h20; #1;
    tests_run++;
    if ({hit0, dout0, hit1, dout1} !== {1'b1, 8'h01, 1'b1, 8'h02}) begin
      failed++;
      $display("FAIL lru_fill: hit0=%b dout0=%h hit1=%b dout1=%h, required 1/01 1/02",
               hit0, dout0, hit1, dout1);
    end
    wr(8'h30, 8'h03);
    ra0 = 8'h20; ra1 = 8'h30; #1;
    tests_run++;
    if ({hit0, dout0, hit1, dout1} !== {1'b1, 8'h02, 1'b1, 8'h03}) begin
      failed++;
      $display("FAIL lru_survivors: hit0=%b dout0=%h hit1=%b dout1=%h, required 1/02 1/03",
               hit0, dout0, hit1, dout1);
    end
    ra0 = 8'h10; #1;
    tests_run++;
    if (hit0 !== 1'b0 || dout0 !== 8'h00) begin
      failed++;
      $display("FAIL lru_evicted: hit0=%b dout0=%h, required 0/00", hit0, dout0);
    end
  endtask

  task automatic test_inplace();
    wr(8'h20, 8'h02);
    wr(8'h20, 8'h55);
    wr(8'h40, 8'h66);
    ra0 = 8'h20; ra1 = 8'h40; #1;
    tests_run++;
    if ({hit0, dout0, hit1, dout1} !== {1'b1, 8'h55, 1'b1, 8'h66}) begin
      failed++;
      $display("FAIL inplace_update: hit0=%b dout0=%h hit1=%b dout1=%h, required 1/55 1/66",
               hit0, dout0, hit1, dout1);
    end
    ra0 = 8'h30; #1;
    tests_run++;
    if (hit0 !== 1'b0) begin
      failed++;
      $display("FAIL inplace_victim: hit0=%b for 0x30, required 0", hit0);
    end
  endtask

  task automatic test_dual_port();
    do_reset();
    wr(8'h10, 8'h01);
    ra0 = 8'h10; ra1 = 8'h11; #1;
    tests_run++;
    if ({hit0, dout0, hit1, dout1} !== {1'b1, 8'h01, 1'b0, 8'h00}) begin
      failed++;
      $display("FAIL dual_port: hit0=%b dout0=%h hit1=%b dout1=%h, required 1/01 0/00",
               hit0, dout0, hit1, dout1);
    end
  endtask

  task automatic test_flush();
    int n;
    logic eh0, eh1;
    logic [DW-1:0] ed0, ed1;
    do_reset();
    for (int i = 0; i < NS; i++) begin
      wr(8'(8'h10 + i), 8'(8'hA0 + i));
      wr(8'(8'h20 + i), 8'(8'hB0 + i));
    end
    ra0 = 8'h10; ra1 = 8'h23;
    flush = 1'b1; #1;
    tests_run++;
    if (busy !== 1'b0 || hit0 !== 1'b1 || hit1 !== 1'b1) begin
      failed++;
      $display("FAIL flush_pre_edge: busy=%b hit0=%b hit1=%b, required 0 1 1", busy, hit0, hit1);
    end
    tick();
    flush = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && busy; c++) begin
      n++;
      tests_run++;
      if ({hit0, dout0, hit1, dout1} !== 18'b0) begin
        failed++;
        $display("FAIL flush_masks_reads: hit0=%b dout0=%h hit1=%b dout1=%h, required all zero",
                 hit0, dout0, hit1, dout1);
      end
      we = (c == 1); wa = 8'h05; din = 8'h77;
      flush = (c == 2);
      tick();
      we = 1'b0; flush = 1'b0;
    end
    tests_run++;
    if (n !== NS) begin
      failed++;
      $display("FAIL flush_busy_length: busy cycles=%0d, required %0d", n, NS);
    end
    for (int i = 0; i < NS; i++) begin
      ra0 = 8'(8'h10 + i); ra1 = 8'(8'h20 + i); #1;
      tests_run++;
      if (hit0 !== 1'b0 || hit1 !== 1'b0) begin
        failed++;
        $display("FAIL flush_cleared: addr %h/%h hit0=%b hit1=%b, required 0 0", ra0, ra1, hit0, hit1);
      end
    end
    ra0 = 8'h05; #1;
    m_read(ra0, eh0, ed0);
    tests_run++;
    if (hit0 !== 1'b0 || {hit0, dout0} !== {eh0, ed0}) begin
      failed++;
      $display("FAIL flush_write_dropped: hit0=%b dout0=%h, required 0/00", hit0, dout0);
    end
    ra1 = 8'h05; #1;
    m_read(ra1, eh1, ed1);
    tests_run++;
    if ({hit1, dout1} !== {eh1, ed1}) begin
      failed++;
      $display("FAIL flush_model_agree: hit1=%b dout1=%h, required %b/%h", hit1, dout1, eh1, ed1);
    end
  endtask

  task automatic test_we_flush_same();
    we = 1'b1; wa = 8'h33; din = 8'h12; flush = 1'b1;
    tick();
    we = 1'b0; flush = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL we_flush_busy: busy=%b, required 1", busy);
    end
    for (int c = 0; c < 20 && busy; c++) tick();
    ra0 = 8'h33; #1;
    tests_run++;
    if (busy !== 1'b0 || hit0 !== 1'b0) begin
      failed++;
      $display("FAIL we_flush_cleared: busy=%b hit0=%b, required 0 0", busy, hit0);
    end
  endtask

  task automatic test_async_reset();
    wr(8'h12, 8'h34);
    ra0 = 8'h12; ra1 = 8'h12; #1;
    tests_run++;
    if (hit0 !== 1'b1 || hit1 !== 1'b1) begin
      failed++;
      $display("FAIL async_setup_hit: hit0=%b hit1=%b, required 1 1", hit0, hit1);
    end
    #2;
    reset_n = 1'b0;
    m_clear();
    m_busy_left = 0;
    #1;
    tests_run++;
    if ({hit0, dout0, hit1, dout1} !== 18'b0) begin
      failed++;
      $display("FAIL async_reset_hits: hit0=%b dout0=%h hit1=%b dout1=%h, required all zero",
               hit0, dout0, hit1, dout1);
    end
    #2;
    reset_n = 1'b1;
    tick();
    wr(8'h12, 8'h34);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      failed++;
      $display("FAIL async_mid_flush_busy: busy=%b, required 1", busy);
    end
    #2;
    reset_n = 1'b0;
    m_clear();
    m_busy_left = 0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || hit0 !== 1'b0 || hit1 !== 1'b0) begin
      failed++;
      $display("FAIL async_reset_busy: busy=%b hit0=%b hit1=%b, required 0 0 0", busy, hit0, hit1);
    end
    #2;
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (hit0 !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL async_after_release: hit0=%b busy=%b, required 0 0", hit0, busy);
    end
    wr(8'h12, 8'h99);
    #1;
    tests_run++;
    if ({hit0, dout0, hit1, dout1} !== {1'b1, 8'h99, 1'b1, 8'h99}) begin
      failed++;
      $display("FAIL async_write_read: hit0=%b dout0=%h hit1=%b dout1=%h, required 1/99 1/99",
               hit0, dout0, hit1, dout1);
    end
  endtask

  task automatic test_random();
    logic eh0, eh1, eb;
    logic [DW-1:0] ed0, ed1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ra0   = 8'(($urandom_range(0, 4) << 2) | $urandom_range(0, 3));
      ra1   = 8'(($urandom_range(0, 4) << 2) | $urandom_range(0, 3));
      wa    = 8'(($urandom_range(0, 4) << 2) | $urandom_range(0, 3));
      din   = 8'($urandom);
      we    = ($urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 99) < 3);
      #1;
      m_read(ra0, eh0, ed0);
      m_read(ra1, eh1, ed1);
      eb = (m_busy_left > 0);
      tests_run++;
      if ({busy, hit0, dout0, hit1, dout1} !== {eb, eh0, ed0, eh1, ed1}) begin
        failed++;
        $display("FAIL random_cycle%0d: busy=%b hit0=%b dout0=%h hit1=%b dout1=%h, required %b %b/%h %b/%h",
                 c, busy, hit0, dout0, hit1, dout1, eb, eh0, ed0, eh1, ed1);
      end
      tick();
    end
    we = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_lru();
    test_inplace();
    test_dual_port();
    test_flush();
    test_we_flush_same();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
